// File: rtl/round_key_store.sv
// AES round-key store: holds the expanded key schedule as 64-bit words and serves one 128-bit round key per handshake.
// Latency: rk_valid is high 2 clocks after the edge that accepts rk_start or rk_ack. Peak rate is one key per 3 cycles.
// Backpressure: rk_valid, rk_data and rk_round hold steady until rk_ack. key_start aborts a running sequence.
module round_key_store #(
    parameter int WORDS  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        key_mode,
    input  logic              key_start,
    input  logic              kx_wr,
    input  logic [ADDR_W-1:0] kx_wr_addr,
    input  logic [63:0]       kx_wr_data,
    input  logic              kx_key_ready,
    input  logic              rk_start,
    input  logic              rk_decrypt,
    input  logic              rk_ack,
    output logic              rk_valid,
    output logic [127:0]      rk_data,
    output logic [3:0]        rk_round,
    output logic              rk_last,
    output logic              rk_done,
    output logic              rk_err,
    output logic              keys_valid,
    output logic              busy
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_FETCH_HI = 2'd1;
    localparam logic [1:0] S_FETCH_LO = 2'd2;
    localparam logic [1:0] S_HOLD     = 2'd3;

    // Key storage. It is not reset; keys_valid says whether it holds a usable schedule.
    logic [63:0]       r_mem [WORDS];

    logic [1:0]        r_state;
    logic [3:0]        r_ptr;
    logic [3:0]        r_nr;
    logic              r_dec;
    logic [127:0]      r_data;
    logic [3:0]        r_round;
    logic              r_done;
    logic              r_err;
    logic              r_keys_valid;

    logic [3:0]        w_nr;
    logic              w_last;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [63:0]       w_rd_data;

    // Round count for the selected key size. Both 10 and 11 select AES-256.
    always_comb begin
        case (key_mode)
            2'b00:   w_nr = 4'd10;
            2'b01:   w_nr = 4'd12;
            default: w_nr = 4'd14;
        endcase
    end

    // The final key is round Nr for ascending order and round 0 for descending order.
    assign w_last    = r_dec ? (r_ptr == 4'd0) : (r_ptr == r_nr);

    // Single read port. The even word is read in FETCH_HI and the odd word in FETCH_LO.
    assign w_rd_addr = ADDR_W'({r_ptr, (r_state == S_FETCH_LO)});
    assign w_rd_data = r_mem[w_rd_addr];

    assign rk_valid   = (r_state == S_HOLD);
    assign rk_last    = (r_state == S_HOLD) && w_last;
    assign busy       = (r_state != S_IDLE);
    assign rk_data    = r_data;
    assign rk_round   = r_round;
    assign rk_done    = r_done;
    assign rk_err     = r_err;
    assign keys_valid = r_keys_valid;

    // Key-word writes, accepted in any state. A read of the same address in this cycle sees the old word.
    always_ff @(posedge clk) begin
        if (kx_wr) begin
            r_mem[kx_wr_addr] <= kx_wr_data;
        end
    end

    // Schedule validity. A new expansion invalidates the schedule, and key_start wins over kx_key_ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_keys_valid <= 1'b0;
        end else if (key_start) begin
            r_keys_valid <= 1'b0;
        end else if (kx_key_ready) begin
            r_keys_valid <= 1'b1;
        end
    end

    // Sequencer: two fetches per round key, then hold the key until it is acked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= 4'd0;
            r_nr    <= 4'd0;
            r_dec   <= 1'b0;
            r_data  <= '0;
            r_round <= 4'd0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (key_start && (r_state != S_IDLE)) begin
                // A new expansion abandons the sequence quietly, without rk_done.
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (rk_start) begin
                            if (r_keys_valid && !key_start) begin
                                r_nr    <= w_nr;
                                r_dec   <= rk_decrypt;
                                r_ptr   <= rk_decrypt ? w_nr : 4'd0;
                                r_state <= S_FETCH_HI;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    S_FETCH_HI: begin
                        r_data[127:64] <= w_rd_data;
                        r_state        <= S_FETCH_LO;
                    end
                    S_FETCH_LO: begin
                        r_data[63:0] <= w_rd_data;
                        r_round      <= r_ptr;
                        r_state      <= S_HOLD;
                    end
                    S_HOLD: begin
                        if (rk_ack) begin
                            if (w_last) begin
                                r_done  <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_ptr   <= r_dec ? (r_ptr - 4'd1) : (r_ptr + 4'd1);
                                r_state <= S_FETCH_HI;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_round_key_store.sv
// Directed bench for round_key_store: FIPS-197 AES-128 encrypt, AES-256 decrypt, error, backpressure, abort and reset cases.
// Expected keys come from the FIPS-197 table or from a bench-side word pattern. Outputs are sampled 1 ns after the rising edge.
// Every wait on the DUT has a cycle budget, and a wait that runs out counts as a miscompare.
module tb_round_key_store;

    logic         clk;
    logic         reset;
    logic [1:0]   key_mode;
    logic         key_start;
    logic         kx_wr;
    logic [4:0]   kx_wr_addr;
    logic [63:0]  kx_wr_data;
    logic         kx_key_ready;
    logic         rk_start;
    logic         rk_decrypt;
    logic         rk_ack;
    logic         rk_valid;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;
    logic         rk_last;
    logic         rk_done;
    logic         rk_err;
    logic         keys_valid;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    // FIPS-197 Appendix A.1 round keys for the key 2b7e1516_28aed2a6_abf71588_09cf4f3c.
    logic [127:0] rk128 [0:10] = '{
        128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
        128'ha0fafe17_88542cb1_23a33939_2a6c7605,
        128'hf2c295f2_7a96b943_5935807a_7367f6b0,
        128'h3d80477d_4716fe3e_1e237e44_6d7a883b,
        128'hef44a541_a8525b7f_b671253b_db0bad00,
        128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc,
        128'h6d88a37a_110b3efd_dbf98641_ca0093fd,
        128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f,
        128'head27321_b58dbad2_312bf560_7f8d292f,
        128'hac7766f3_19fadc21_28d12941_575c006e,
        128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6
    };

    round_key_store dut (
        .clk          (clk),
        .reset        (reset),
        .key_mode     (key_mode),
        .key_start    (key_start),
        .kx_wr        (kx_wr),
        .kx_wr_addr   (kx_wr_addr),
        .kx_wr_data   (kx_wr_data),
        .kx_key_ready (kx_key_ready),
        .rk_start     (rk_start),
        .rk_decrypt   (rk_decrypt),
        .rk_ack       (rk_ack),
        .rk_valid     (rk_valid),
        .rk_data      (rk_data),
        .rk_round     (rk_round),
        .rk_last      (rk_last),
        .rk_done      (rk_done),
        .rk_err       (rk_err),
        .keys_valid   (keys_valid),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pattern used for the synthetic AES-256 schedule. Each word differs in the address byte.
    function automatic logic [63:0] pat(input int a);
        return {8'hA0, 8'(a), 16'h1234, 8'hB0, 8'(a), 16'(a * 7)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int addr, input logic [63:0] data);
        kx_wr      = 1'b1;
        kx_wr_addr = 5'(addr);
        kx_wr_data = data;
        tick();
        kx_wr = 1'b0;
    endtask

    // Returns the number of clocks until rk_valid is seen, or -1 if the budget runs out.
    task automatic wait_valid(output int n);
        n = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (rk_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_vec++;
        if ({rk_valid, rk_data, rk_round, rk_last, rk_done, rk_err, keys_valid, busy} !== 138'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b d=%h r=%0d l=%b dn=%b e=%b kv=%b b=%b, want all 0",
                     rk_valid, rk_data, rk_round, rk_last, rk_done, rk_err, keys_valid, busy);
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
        n_vec++;
        if ({rk_valid, rk_last, rk_done, rk_err, keys_valid, busy} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_release: got flags %b, want 000000",
                     {rk_valid, rk_last, rk_done, rk_err, keys_valid, busy});
        end
    endtask

    task automatic test_err_before_ready();
        rk_start = 1'b1;
        tick();
        rk_start = 1'b0;
        n_vec++;
        if ({rk_err, busy, rk_valid} !== 3'b100) begin
            n_err++;
            $display("FAIL err_pulse: got err/busy/valid=%b, want 100", {rk_err, busy, rk_valid});
        end
        tick();
        n_vec++;
        if ({rk_err, busy, rk_valid} !== 3'b000) begin
            n_err++;
            $display("FAIL err_one_cycle: got err/busy/valid=%b, want 000", {rk_err, busy, rk_valid});
        end
    endtask

    task automatic test_aes128_enc();
        int k;
        int done_cnt;
        key_mode = 2'b00;
        for (int r = 0; r <= 10; r++) begin
            write_word(2 * r, rk128[r][127:64]);
            write_word(2 * r + 1, rk128[r][63:0]);
        end
        kx_key_ready = 1'b1;
        tick();
        n_vec++;
        if (keys_valid !== 1'b1) begin
            n_err++;
            $display("FAIL keys_valid_set: got %b, want 1", keys_valid);
        end
        rk_decrypt = 1'b0;
        rk_ack     = 1'b1;
        rk_start   = 1'b1;
        tick();
        rk_start = 1'b0;
        // This mode change must not affect the sequence, because Nr was latched at rk_start.
        key_mode = 2'b10;
        n_vec++;
        if ({busy, rk_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL enc_start: got busy/valid=%b, want 10", {busy, rk_valid});
        end
        k = 0;
        done_cnt = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            tick();
            if (rk_done) done_cnt++;
            if (rk_valid) begin
                n_vec++;
                if (k > 10 || rk_round !== 4'(k) || rk_data !== rk128[(k > 10) ? 10 : k] ||
                    rk_last !== (k == 10) || cyc != 2 + 3 * k) begin
                    n_err++;
                    $display("FAIL enc128_key%0d: got cyc=%0d r=%0d l=%b d=%h, want cyc=%0d r=%0d l=%b d=%h",
                             k, cyc, rk_round, rk_last, rk_data, 2 + 3 * k, k, (k == 10),
                             rk128[(k > 10) ? 10 : k]);
                end
                k++;
            end
        end
        n_vec++;
        if (k != 11 || done_cnt != 1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL enc128_end: got keys=%0d done=%0d busy=%b, want 11 1 0", k, done_cnt, busy);
        end
        rk_ack   = 1'b0;
        key_mode = 2'b00;
    endtask

    task automatic test_backpressure();
        int n;
        logic ok;
        rk_decrypt = 1'b0;
        rk_start   = 1'b1;
        tick();
        rk_start = 1'b0;
        // Overwrite word 0 in the same cycle that FETCH_HI reads it. The key must still carry the old word.
        kx_wr      = 1'b1;
        kx_wr_addr = 5'd0;
        kx_wr_data = 64'hDEAD_BEEF_0BAD_F00D;
        tick();
        kx_wr_data = rk128[0][127:64];
        tick();
        kx_wr = 1'b0;
        n_vec++;
        if (rk_valid !== 1'b1 || rk_data !== rk128[0]) begin
            n_err++;
            $display("FAIL collision_old_data: got v=%b d=%h, want v=1 d=%h", rk_valid, rk_data, rk128[0]);
        end
        for (int r = 0; r < 3; r++) begin
            rk_ack = 1'b1;
            tick();
            rk_ack = 1'b0;
            wait_valid(n);
            n_vec++;
            if (n != 2 || rk_round !== 4'(r + 1)) begin
                n_err++;
                $display("FAIL bp_advance%0d: got clocks=%0d r=%0d, want 2 %0d", r, n, rk_round, r + 1);
            end
        end
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rk_valid !== 1'b1 || rk_round !== 4'd3 || rk_data !== rk128[3] || rk_last !== 1'b0) ok = 1'b0;
        end
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL bp_hold: got v=%b r=%0d d=%h, want v=1 r=3 d=%h", rk_valid, rk_round, rk_data, rk128[3]);
        end
        rk_ack = 1'b1;
        tick();
        rk_ack = 1'b0;
        n_vec++;
        if (rk_valid !== 1'b0 || rk_round !== 4'd3) begin
            n_err++;
            $display("FAIL bp_ack_edge: got v=%b r=%0d, want v=0 r=3", rk_valid, rk_round);
        end
        wait_valid(n);
        n_vec++;
        if (n != 2 || rk_round !== 4'd4 || rk_data !== rk128[4]) begin
            n_err++;
            $display("FAIL bp_round4: got clocks=%0d r=%0d d=%h, want 2 4 %h", n, rk_round, rk_data, rk128[4]);
        end
    endtask

    task automatic test_key_start_abort();
        logic ok;
        kx_key_ready = 1'b0;
        key_start    = 1'b1;
        tick();
        key_start = 1'b0;
        n_vec++;
        if ({busy, rk_valid, rk_last, keys_valid, rk_done} !== 5'b0) begin
            n_err++;
            $display("FAIL abort_next_edge: got busy/v/last/kv/done=%b, want 00000",
                     {busy, rk_valid, rk_last, keys_valid, rk_done});
        end
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rk_done !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL abort_no_done: got done=%b busy=%b, want 0 0", rk_done, busy);
        end
        rk_start = 1'b1;
        tick();
        rk_start = 1'b0;
        n_vec++;
        if ({rk_err, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL abort_then_err: got err/busy=%b, want 10", {rk_err, busy});
        end
    endtask

    task automatic test_aes256_dec();
        int k;
        int done_cnt;
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        for (int a = 0; a < 30; a++) write_word(a, pat(a));
        kx_key_ready = 1'b1;
        key_mode     = 2'b10;
        rk_decrypt   = 1'b1;
        tick();
        rk_ack   = 1'b1;
        rk_start = 1'b1;
        tick();
        rk_start = 1'b0;
        k = 0;
        done_cnt = 0;
        for (int cyc = 1; cyc <= 50; cyc++) begin
            tick();
            if (rk_done) done_cnt++;
            if (rk_valid) begin
                n_vec++;
                if (k > 14 || rk_round !== 4'(14 - k) ||
                    rk_data !== {pat(2 * (14 - k)), pat(2 * (14 - k) + 1)} ||
                    rk_last !== (k == 14) || cyc != 2 + 3 * k) begin
                    n_err++;
                    $display("FAIL dec256_key%0d: got cyc=%0d r=%0d l=%b d=%h, want cyc=%0d r=%0d l=%b d=%h",
                             k, cyc, rk_round, rk_last, rk_data, 2 + 3 * k, 14 - k, (k == 14),
                             {pat(2 * (14 - k)), pat(2 * (14 - k) + 1)});
                end
                k++;
            end
        end
        n_vec++;
        if (k != 15 || done_cnt != 1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL dec256_end: got keys=%0d done=%0d busy=%b, want 15 1 0", k, done_cnt, busy);
        end
        rk_ack     = 1'b0;
        rk_decrypt = 1'b0;
    endtask

    task automatic test_async_reset();
        int n;
        rk_start = 1'b1;
        tick();
        rk_start = 1'b0;
        wait_valid(n);
        n_vec++;
        if (n != 2) begin
            n_err++;
            $display("FAIL areset_setup: got clocks=%0d, want 2", n);
        end
        #2;
        reset        = 1'b1;
        kx_key_ready = 1'b0;
        #1;
        n_vec++;
        if ({rk_valid, rk_data, rk_round, rk_last, rk_done, rk_err, keys_valid, busy} !== 138'b0) begin
            n_err++;
            $display("FAIL areset_no_edge: got v=%b d=%h r=%0d l=%b dn=%b e=%b kv=%b b=%b, want all 0",
                     rk_valid, rk_data, rk_round, rk_last, rk_done, rk_err, keys_valid, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        rk_start = 1'b1;
        tick();
        rk_start = 1'b0;
        n_vec++;
        if ({rk_err, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL areset_then_err: got err/busy=%b, want 10", {rk_err, busy});
        end
        write_word(0, pat(0));
        kx_key_ready = 1'b1;
        tick();
        kx_key_ready = 1'b0;
        rk_start = 1'b1;
        tick();
        rk_start = 1'b0;
        n_vec++;
        if ({rk_err, busy, keys_valid} !== 3'b011) begin
            n_err++;
            $display("FAIL areset_rewrite_start: got err/busy/kv=%b, want 011", {rk_err, busy, keys_valid});
        end
    endtask

    initial begin
        reset        = 1'b1;
        key_mode     = 2'b00;
        key_start    = 1'b0;
        kx_wr        = 1'b0;
        kx_wr_addr   = 5'd0;
        kx_wr_data   = 64'd0;
        kx_key_ready = 1'b0;
        rk_start     = 1'b0;
        rk_decrypt   = 1'b0;
        rk_ack       = 1'b0;
        test_reset();
        test_err_before_ready();
        test_aes128_enc();
        test_backpressure();
        test_key_start_abort();
        test_aes256_dec();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
